// File: rtl/qspi_fetch_buffer.sv
// qspi_fetch_buffer: single-line read buffer in front of qspi_controller.
// Serves hits from the buffered line. A miss refills the whole line, critical word first.
module qspi_fetch_buffer #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              s_pclk,
  input  logic              s_presetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  input  logic              flush,
  output logic [ADDR_W-1:0] m_paddr,
  output logic              m_psel,
  output logic              m_pwrite,
  input  logic              m_pready,
  input  logic [31:0]       m_prdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HIT       = 3'd1,
    REQ       = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DROP = 3'd4
  } state_e;

  state_e                           state_q, state_d;
  logic                             line_valid_q, line_valid_d;
  logic [LINE_WORDS-1:0]            word_valid_q, word_valid_d;
  logic [LINE_WORDS-1:0][DATA_W-1:0] words_q, words_d;
  logic [TAG_W-1:0]                 tag_q, tag_d;
  logic [IDX_W-1:0]                 fill_idx_q, fill_idx_d;
  logic [IDX_W-1:0]                 req_idx_q, req_idx_d;
  logic [IDX_W-1:0]                 cnt_q, cnt_d;
  logic                             pend_q, pend_d;
  logic                             abort_q, abort_d;
  logic                             req_ready_q, req_ready_d;
  logic                             rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]                rsp_data_q, rsp_data_d;
  logic                             m_psel_q, m_psel_d;
  logic [ADDR_W-1:0]                m_paddr_q, m_paddr_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             unused_addr_lsb;

  assign req_tag         = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx         = req_addr[IDX_W+1:2];
  assign unused_addr_lsb = ^req_addr[1:0];

  // A flush in the same cycle as a request wins, so the handshake is masked by it.
  assign req_ready = req_ready_q & ~flush;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign m_psel    = m_psel_q;
  assign m_paddr   = m_paddr_q;
  assign m_pwrite  = 1'b0;

  // Next-state and registered-output logic for the lookup/refill sequencer.
  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    word_valid_d = word_valid_q;
    words_d      = words_q;
    tag_d        = tag_q;
    fill_idx_d   = fill_idx_q;
    req_idx_d    = req_idx_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    abort_d      = abort_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    m_psel_d     = m_psel_q;
    m_paddr_d    = m_paddr_q;

    case (state_q)
      IDLE: begin
        if (flush) begin
          line_valid_d = 1'b0;
        end else if (req_valid && req_ready_q) begin
          if (line_valid_q && (tag_q == req_tag) && word_valid_q[req_idx]) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = words_q[req_idx];
            state_d     = HIT;
          end else begin
            line_valid_d = 1'b0;
            word_valid_d = '0;
            tag_d        = req_tag;
            fill_idx_d   = req_idx;
            req_idx_d    = req_idx;
            cnt_d        = '0;
            pend_d       = 1'b1;
            abort_d      = 1'b0;
            state_d      = REQ;
          end
        end
      end

      HIT: begin
        if (flush) line_valid_d = 1'b0;
        state_d = IDLE;
      end

      REQ: begin
        // No transfer is on the bus yet, so a flush here can leave immediately.
        if (flush) begin
          line_valid_d = 1'b0;
          pend_d       = 1'b0;
          abort_d      = 1'b0;
          state_d      = IDLE;
        end else begin
          m_psel_d  = 1'b1;
          m_paddr_d = {tag_q, fill_idx_q, 2'b00};
          state_d   = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (flush) abort_d = 1'b1;
        if (m_pready) begin
          m_psel_d = 1'b0;
          pend_d   = 1'b0;
          state_d  = WAIT_DROP;
          if (!(abort_q || flush)) begin
            words_d[fill_idx_q]      = m_prdata;
            word_valid_d[fill_idx_q] = 1'b1;
            if (pend_q && (fill_idx_q == req_idx_q)) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = m_prdata;
            end
          end
        end
      end

      WAIT_DROP: begin
        if (flush) abort_d = 1'b1;
        if (!m_pready) begin
          if (abort_q || flush) begin
            line_valid_d = 1'b0;
            abort_d      = 1'b0;
            pend_d       = 1'b0;
            state_d      = IDLE;
          end else if (cnt_q == IDX_W'(LINE_WORDS - 1)) begin
            line_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            fill_idx_d = fill_idx_q + IDX_W'(1);
            cnt_d      = cnt_q + IDX_W'(1);
            state_d    = REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge s_pclk or negedge s_presetn) begin
    if (!s_presetn) begin
      state_q      <= IDLE;
      line_valid_q <= 1'b0;
      word_valid_q <= '0;
      words_q      <= '0;
      tag_q        <= '0;
      fill_idx_q   <= '0;
      req_idx_q    <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      abort_q      <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      m_psel_q     <= 1'b0;
      m_paddr_q    <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      word_valid_q <= word_valid_d;
      words_q      <= words_d;
      tag_q        <= tag_d;
      fill_idx_q   <= fill_idx_d;
      req_idx_q    <= req_idx_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      abort_q      <= abort_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      m_psel_q     <= m_psel_d;
      m_paddr_q    <= m_paddr_d;
    end
  end

endmodule

// File: tb/tb_qspi_fetch_buffer.sv
// Bench for qspi_fetch_buffer: line-buffer model, per-cycle compare, directed scenarios.
module tb_qspi_fetch_buffer;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LW     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              flush;
  logic [ADDR_W-1:0] m_paddr;
  logic              m_psel;
  logic              m_pwrite;
  logic              m_pready;
  logic [31:0]       m_prdata;

  qspi_fetch_buffer #(.ADDR_W(ADDR_W), .LINE_WORDS(LW)) dut (
    .s_pclk    (clk),
    .s_presetn (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .flush     (flush),
    .m_paddr   (m_paddr),
    .m_psel    (m_psel),
    .m_pwrite  (m_pwrite),
    .m_pready  (m_pready),
    .m_prdata  (m_prdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Controller stand-in: one-cycle pready three cycles after psel, prdata = ~paddr.
  initial begin
    int age;
    age      = 0;
    m_pready = 1'b0;
    m_prdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || m_pready) begin
        m_pready = 1'b0;
        age      = 0;
      end else if (m_psel) begin
        age++;
        if (age == 3) begin
          m_pready = 1'b1;
          m_prdata = ~m_paddr;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Model state: which line the buffer holds and which fetches/responses are owed.
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  bit          mdl_valid, exp_rsp_now, pending, fill_active, abort_f, hit_pend;
  bit          psel_prev, pready_prev, nxt_rsp, nxt_hit;
  logic [31:0] mdl_base, exp_data, cur_addr, tmp_addr, waddr;
  int          widx;

  // Per-cycle compare of the DUT against the line-buffer model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_valid   = 0; exp_rsp_now = 0; pending  = 0; fill_active = 0;
      abort_f     = 0; hit_pend    = 0; psel_prev = 0; pready_prev = 0;
    end else begin
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_now));
      if (rsp_valid && exp_rsp_now) check("rsp_data", rsp_data, exp_data);
      check("m_pwrite", 32'(m_pwrite), 32'd0);
      if (m_psel && !psel_prev) begin
        check("psel_rise_with_pready", 32'(m_pready), 32'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_psel: paddr 0x%08h with no fetch owed", m_paddr);
        end else begin
          tmp_addr = exp_q.pop_front();
          check("m_paddr", m_paddr, tmp_addr);
        end
        log_q.push_back(m_paddr);
        cur_addr = m_paddr;
      end
      if (m_psel && psel_prev) check("m_paddr_stable", m_paddr, cur_addr);
      if (!m_psel && psel_prev) check("psel_drop_after_pready", 32'(pready_prev), 32'd1);
      if (fill_active || hit_pend) check("req_ready_busy", 32'(req_ready), 32'd0);

      nxt_rsp = 0;
      nxt_hit = 0;
      if (m_psel && m_pready) begin
        if (pending && !abort_f) begin
          nxt_rsp = 1;
          pending = 0;
        end
        if (exp_q.size() == 0 && fill_active) begin
          if (!abort_f) mdl_valid = 1;
          fill_active = 0;
          abort_f     = 0;
        end
      end
      if (flush) begin
        mdl_valid = 0;
        if (fill_active) begin
          pending = 0;
          exp_q.delete();
          if (m_psel && !m_pready) abort_f = 1;
          else begin
            fill_active = 0;
            abort_f     = 0;
          end
        end
      end
      if (req_valid && req_ready) begin
        waddr    = req_addr & ~32'h3;
        exp_data = ~waddr;
        if (mdl_valid && ((req_addr & ~32'hF) == mdl_base)) begin
          nxt_rsp = 1;
          nxt_hit = 1;
        end else begin
          mdl_valid = 0;
          mdl_base  = req_addr & ~32'hF;
          widx      = int'((waddr >> 2) & 32'h3);
          exp_q.delete();
          for (int k = 0; k < int'(LW); k++)
            exp_q.push_back(mdl_base | 32'(((widx + k) % int'(LW)) * 4));
          pending     = 1;
          fill_active = 1;
          abort_f     = 0;
        end
      end
      exp_rsp_now = nxt_rsp;
      hit_pend    = nxt_hit;
      psel_prev   = m_psel;
      pready_prev = m_pready;
    end
  end

  int acc_log;

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    int n;
    n = 0;
    d = '0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_total++;
      $display("FAIL accept_timeout: addr 0x%08h never accepted", a);
      req_valid = 1'b0;
      lat = -1;
      return;
    end
    acc_log = log_q.size();
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        d = rsp_data;
        break;
      end
    end
    if (!rsp_valid) begin
      n_total++;
      $display("FAIL rsp_timeout: no response for addr 0x%08h", a);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_total++;
      $display("FAIL ready_timeout: req_ready still 0 after %0d cycles", n);
    end
  endtask

  task automatic wait_psel(input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_psel && m_paddr == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(m_psel && m_paddr == a)) begin
      n_total++;
      $display("FAIL psel_timeout: no transfer to 0x%08h", a);
    end
  endtask

  task automatic check_seq(input string name, input int mark,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e[4];
    e = '{e0, e1, e2, e3};
    check({name, "_count"}, 32'(log_q.size() - mark), 32'd4);
    for (int i = 0; i < 4; i++)
      if (mark + i < log_q.size()) check(name, log_q[mark + i], e[i]);
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    int          mark;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_m_psel",    32'(m_psel), 32'd0);
    check("rst_m_paddr",   m_paddr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 32'd1);

    // 1 Cold miss, critical word first with wrap
    mark = log_q.size();
    do_read(32'h78, d, lat);
    check("cold_miss_data", d, 32'hFFFFFF87);
    wait_ready();
    check_seq("cold_miss_paddr", mark, 32'h78, 32'h7C, 32'h70, 32'h74);

    // 2 Hits, one cycle latency, no bus traffic
    mark = log_q.size();
    do_read(32'h74, d, lat);
    check("hit_data", d, 32'hFFFFFF8B);
    check("hit_latency", 32'(lat), 32'd1);
    wait_ready();
    do_read(32'h78, d, lat);
    check("hit2_data", d, 32'hFFFFFF87);
    check("hit2_latency", 32'(lat), 32'd1);
    wait_ready();
    check("hit_no_psel", 32'(log_q.size() - mark), 32'd0);

    // 3 Miss replaces the line, old line then misses
    mark = log_q.size();
    do_read(32'h80, d, lat);
    check("replace_data", d, 32'hFFFFFF7F);
    wait_ready();
    check_seq("replace_paddr", mark, 32'h80, 32'h84, 32'h88, 32'h8C);
    mark = log_q.size();
    do_read(32'h70, d, lat);
    check("remiss_data", d, 32'hFFFFFF8F);
    wait_ready();
    check_seq("remiss_paddr", mark, 32'h70, 32'h74, 32'h78, 32'h7C);

    // 4 Flush during the second transfer of a fill
    mark = log_q.size();
    do_read(32'h300, d, lat);
    check("flushfill_data", d, 32'hFFFFFCFF);
    wait_psel(32'h304);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_ready();
    repeat (10) @(negedge clk);
    check("flush_stops_fill", 32'(log_q.size() - mark), 32'd2);
    do_read(32'h300, d, lat);
    check("after_flush_miss_data", d, 32'hFFFFFCFF);
    check("after_flush_misses", 32'(log_q.size() - mark), 32'd3);
    if (log_q.size() - mark >= 3) check("after_flush_first_paddr", log_q[mark + 2], 32'h300);
    wait_ready();

    // Flush together with a request in IDLE: flush wins
    @(posedge clk); #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h304;
    @(negedge clk);
    check("flush_wins_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    mark = log_q.size();
    do_read(32'h304, d, lat);
    check("flush_idle_miss_data", d, 32'hFFFFFCFB);
    wait_ready();
    check_seq("flush_idle_paddr", mark, 32'h304, 32'h308, 32'h30C, 32'h300);

    // 6 Request held during a fill is accepted only after the line completes
    mark = log_q.size();
    do_read(32'h208, d, lat);
    check("held_first_data", d, 32'hFFFFFDF7);
    do_read(32'h20C, d, lat);
    check("held_accept_after_fill", 32'(acc_log - mark), 32'd4);
    check("held_hit_data", d, 32'hFFFFFDF3);
    check("held_hit_latency", 32'(lat), 32'd1);
    wait_ready();

    // 5 Reset in the middle of a fill
    do_read(32'h400, d, lat);
    check("prereset_data", d, 32'hFFFFFBFF);
    wait_psel(32'h404);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_psel", 32'(m_psel), 32'd0);
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rerelease", 32'(req_ready), 32'd1);
    mark = log_q.size();
    do_read(32'h78, d, lat);
    check("post_reset_data", d, 32'hFFFFFF87);
    wait_ready();
    check_seq("post_reset_paddr", mark, 32'h78, 32'h7C, 32'h70, 32'h74);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
